// File: rtl/wb_uart_rx.sv
// wb_uart_rx: 8N1 UART receiver with a 16-entry receive FIFO behind a
// single-cycle-ack Wishbone slave (DATA at adr 0, STATUS at adr 1).
//
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   rxd                 async serial input, idle high
//   cyc_i, stb_i, we_i  Wishbone cycle/strobe/write (stb_i pre-decoded)
//   adr_i               0 = DATA, 1 = STATUS
//   dat_i               write data (ignored)
//   dat_o, ack_o        registered read data and one-cycle acknowledge
//   irq_o               high while the FIFO holds data
module wb_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic        adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        irq_o
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        idx;
    logic [7:0]        shreg;
    logic              rx_m;
    logic              rx_s;

    logic [7:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wp;
    logic [FIFO_AW-1:0] rp;
    logic [FIFO_AW:0]   level;

    logic              frame_err;
    logic              overrun;

    logic              bit_end;
    logic              rx_done;
    logic              push;
    logic              ferr_set;
    logic              empty;
    logic              full;
    logic              req;
    logic              rd_data;
    logic              rd_stat;
    logic              pop;
    logic              wr;
    logic [31:0]       status;
    logic              unused_dat;

    assign unused_dat = ^dat_i;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rxd;
            rx_s <= rx_m;
        end
    end

    assign bit_end  = (cnt == CNT_LAST);
    assign rx_done  = (state == S_STOP) && bit_end;
    assign push     = rx_done & rx_s;
    assign ferr_set = rx_done & ~rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        if (!rx_s) begin
                            state <= S_DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        // LSB arrives first, so shift in from the top
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= '0;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A line held low reports one frame error, not one per frame time
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign empty   = (level == '0);
    assign full    = (level == (FIFO_AW+1)'(DEPTH));
    assign req     = cyc_i & stb_i & ~ack_o;
    assign rd_data = req & ~we_i & ~adr_i;
    assign rd_stat = req & ~we_i & adr_i;
    assign pop     = rd_data & ~empty;
    assign wr      = push & ~full;
    assign status  = {16'b0, 8'(level), 4'b0, frame_err, overrun, full, ~empty};

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            ack_o     <= 1'b0;
            dat_o     <= '0;
            irq_o     <= 1'b0;
        end else begin
            if (wr) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // Setting wins over a same-cycle STATUS read clear
            frame_err <= ferr_set | (frame_err & ~rd_stat);
            overrun   <= (push & full) | (overrun & ~rd_stat);

            // Side effects are taken with the request, so a cyc_i drop
            // after this edge cannot cancel them
            ack_o <= req;
            if (rd_data && !empty) begin
                dat_o <= {23'b0, 1'b1, mem[rp]};
            end else if (rd_stat) begin
                dat_o <= status;
            end else begin
                dat_o <= '0;
            end

            irq_o <= ~empty;
        end
    end

endmodule

// File: tb/tb_wb_uart_rx.sv
// tb_wb_uart_rx: frame-level stimulus on rxd with a byte scoreboard,
// table of frames with expected STATUS, and hand-built corner sequences.
module tb_wb_uart_rx;

    localparam int CPB = 16;

    logic        clk;
    logic        reset_n;
    logic        rxd;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic        adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        irq_o;

    int n_assert;
    int n_fail;

    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic [31:0] status;
    } vec_t;

    vec_t vecs[3];

    wb_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rxd    (rxd),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .irq_o  (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on a negedge
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        if (stop) begin
            if (sb_q.size() < 16) sb_q.push_back(b);
        end
    endtask

    task automatic wb_xfer(input string name, input logic we, input logic adr,
                           input logic [31:0] exp);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        dat_i = $urandom;
        @(posedge clk);
        @(negedge clk);
        check({name, "_ack"}, {31'b0, ack_o}, 32'd1);
        check(name, dat_o, exp);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clk);
        check({name, "_ackfall"}, {31'b0, ack_o}, 32'd0);
    endtask

    task automatic read_data(input string name);
        logic [31:0] exp;
        if (sb_q.size() > 0) exp = {23'b0, 1'b1, sb_q.pop_front()};
        else exp = 32'h0;
        wb_xfer(name, 1'b0, 1'b0, exp);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        rxd      = 1'b1;
        cyc_i    = 1'b0;
        stb_i    = 1'b0;
        we_i     = 1'b0;
        adr_i    = 1'b0;
        dat_i    = '0;

        vecs[0] = '{b: 8'h55, stop: 1'b1, status: 32'h0101};
        vecs[1] = '{b: 8'hA3, stop: 1'b1, status: 32'h0201};
        vecs[2] = '{b: 8'h3C, stop: 1'b0, status: 32'h0209};

        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack_o}, 32'd0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_irq", {31'b0, irq_o}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        wb_xfer("rst_status", 1'b0, 1'b1, 32'h0);

        // Table of frames, STATUS checked after each
        for (int i = 0; i < 3; i++) begin
            send_byte(vecs[i].b, vecs[i].stop);
            rxd = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            wb_xfer($sformatf("tbl_status%0d", i), 1'b0, 1'b1, vecs[i].status);
        end
        check("t1_irq", {31'b0, irq_o}, 32'd1);
        wb_xfer("t1_write", 1'b1, 1'b0, 32'h0);
        read_data("t1_rd0");
        read_data("t1_rd1");
        read_data("t1_rd_empty");
        check("t1_irq_off", {31'b0, irq_o}, 32'd0);

        // Overflow: 17 bytes, 16 fit
        for (int i = 0; i <= 16; i++) send_byte(8'(i), 1'b1);
        repeat (CPB) @(negedge clk);
        wb_xfer("t2_status_full", 1'b0, 1'b1, 32'h1007);
        for (int i = 0; i < 16; i++) read_data($sformatf("t2_rd%0d", i));
        wb_xfer("t2_status_drained", 1'b0, 1'b1, 32'h0);

        // Bad stop bit, then a long break
        send_byte(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        wb_xfer("t3_status_ferr", 1'b0, 1'b1, 32'h0008);
        repeat (40 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        wb_xfer("t3_status_clear", 1'b0, 1'b1, 32'h0);

        // Short glitch on an idle line
        rxd = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        wb_xfer("t4_status", 1'b0, 1'b1, 32'h0);
        check("t4_irq", {31'b0, irq_o}, 32'd0);
        send_byte(8'h5A, 1'b1);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        read_data("t4_rd");

        // DATA read lined up with the stop-bit push
        send_byte(8'h11, 1'b1);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (9 * CPB + CPB - 2) @(negedge clk);
                wb_xfer("t5_rd_coincide", 1'b0, 1'b0, 32'h111);
            end
        join
        rxd = 1'b1;
        // The concurrent read already consumed 0x11 from the model
        void'(sb_q.pop_front());
        repeat (CPB) @(negedge clk);
        wb_xfer("t5_status", 1'b0, 1'b1, 32'h0101);
        read_data("t5_rd_new");

        // Reset in the middle of a frame with bytes queued
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        check("t6_irq_pre", {31'b0, irq_o}, 32'd1);
        rxd = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        adr_i = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_ack_rst", {31'b0, ack_o}, 32'd0);
        check("t6_irq_rst", {31'b0, irq_o}, 32'd0);
        check("t6_dat_rst", dat_o, 32'h0);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        sb_q.delete();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        wb_xfer("t6_status", 1'b0, 1'b1, 32'h0);
        send_byte(8'h7E, 1'b1);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        read_data("t6_rd");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
